reg_file_sb: RTL

Parametrised successor to the RV32I integer register file. Provides one write port, `NUM_RD` combinational read ports and a hardwired-zero entry 0. Adds three things the core pipeline needs: same-cycle write-to-read bypass, a per-entry pending scoreboard for hazard detection, and a self-clearing initialisation sequencer that zeroes every entry after reset. Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/reg_file_sb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with hardwired-zero entry 0, same-cycle
// write-to-read bypass, a per-entry pending scoreboard and a post-reset
// initialisation sweep that zeroes every entry.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-low reset
//   wr_en      - write strobe (ignored during the init sweep)
//   wr_addr    - write address
//   wr_data    - write data
//   rd_addr    - NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    - NUM_RD packed read results, port i at [i*WIDTH +: WIDTH]
//   rd_pending - scoreboard bit for each read address
//   busy_set   - marks busy_addr as having an outstanding producer
//   busy_addr  - scoreboard set address
//   init_done  - high once the init sweep has cleared every entry
module reg_file_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              run;
  logic              wr_accept;
  logic              set_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [ADDR_W-1:0] ra [NUM_RD];

  // Entry 0 is hardwired to zero; addresses at or above DEPTH do not exist.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  assign run        = (state_q == ST_RUN);
  assign wr_accept  = run && wr_en && addr_ok(wr_addr);
  assign set_accept = run && busy_set && addr_ok(busy_addr);
  assign init_done  = init_done_q;

  // The sweep owns the write port while initialising.
  assign mem_we    = run ? wr_accept : 1'b1;
  assign mem_waddr = run ? wr_addr : cnt_q;
  assign mem_wdata = run ? wr_data : '0;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Clear is applied before set so a same-address set wins: a new producer
  // has been issued behind the one that is writing back.
  always_comb begin
    pend_d = pend_q;
    if (wr_accept)  pend_d[wr_addr]   = 1'b0;
    if (set_accept) pend_d[busy_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
    end
  end

  // NOTE: the storage array has no reset; the init sweep clears it over
  // DEPTH cycles so it can map onto plain RAM or a flop array without a
  // wide reset fan-out.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Combinational read ports. Outputs are forced quiet during the sweep; a
  // matching in-flight write forwards its data and resolves the hazard.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run && addr_ok(ra[i])) begin
        if ((BYPASS != 0) && wr_en && (wr_addr == ra[i])) begin
          rd_data[i*WIDTH +: WIDTH] = wr_data;
          rd_pending[i]             = 1'b0;
        end else begin
          rd_data[i*WIDTH +: WIDTH] = mem_q[ra[i]];
          rd_pending[i]             = pend_q[ra[i]];
        end
      end
    end
  end

endmodule
